// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter and sequencer for a single-port
// sample RAM. It grants one word read/write at a time and drives the RAM
// controls. It owns data_bus only during a write ACCESS cycle.
//
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   reqN_valid/write   request pending / 1 = write (N = 0, 1)
//   reqN_addr/wdata    word address / write data
//   reqN_ready         one-cycle accept pulse, the cycle after the grant edge
//   reqN_rvalid/rdata  one-cycle read-data-valid pulse / held read data
//   read_write         RAM direction (1 = write)
//   address            RAM address
//   bus_clr            1 = RAM releases data_bus and ignores controls
//   data_bus           shared bidirectional RAM data bus
module ram_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              read_write,
  output logic [ADDR_W-1:0] address,
  output logic              bus_clr,
  inout  wire  [DATA_W-1:0] data_bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    READ   = 2'd2,
    TURN   = 2'd3
  } state_t;

  state_t              state_q;
  logic                grant_q;
  logic                last_grant_q;
  logic                wr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [ADDR_W-1:0]   address_q;
  logic                read_write_q;
  logic                bus_clr_q;
  logic [1:0]          ready_q;
  logic [1:0]          rvalid_q;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;

  logic                any_req_c;
  logic                pick_c;
  logic                drive_c;

  // Round-robin pick: on contention the port that did not win last time wins.
  always_comb begin
    any_req_c = req0_valid | req1_valid;
    pick_c    = 1'b0;
    if (req0_valid && req1_valid) begin
      pick_c = ~last_grant_q;
    end else if (req1_valid) begin
      pick_c = 1'b1;
    end
  end

  // Tristate enable decoded from state so the bus is released the moment
  // ACCESS ends, without waiting on a register.
  assign drive_c  = (state_q == ACCESS) && wr_q;
  assign data_bus = drive_c ? wdata_q : {DATA_W{1'bz}};

  // Sequencer: IDLE -> ACCESS -> (READ ->) TURN -> IDLE, outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      address_q    <= '0;
      read_write_q <= 1'b0;
      bus_clr_q    <= 1'b1;
      ready_q      <= '0;
      rvalid_q     <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      ready_q  <= '0;
      rvalid_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (any_req_c) begin
            grant_q          <= pick_c;
            last_grant_q     <= pick_c;
            wr_q             <= pick_c ? req1_write : req0_write;
            wdata_q          <= pick_c ? req1_wdata : req0_wdata;
            address_q        <= pick_c ? req1_addr  : req0_addr;
            read_write_q     <= pick_c ? req1_write : req0_write;
            bus_clr_q        <= 1'b0;
            ready_q[pick_c]  <= 1'b1;
            state_q          <= ACCESS;
          end
        end
        ACCESS: begin
          if (wr_q) begin
            bus_clr_q    <= 1'b1;
            read_write_q <= 1'b0;
            state_q      <= TURN;
          end else begin
            state_q <= READ;
          end
        end
        READ: begin
          if (grant_q) begin
            rdata1_q <= data_bus;
          end else begin
            rdata0_q <= data_bus;
          end
          rvalid_q[grant_q] <= 1'b1;
          bus_clr_q         <= 1'b1;
          read_write_q      <= 1'b0;
          state_q           <= TURN;
        end
        TURN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready  = ready_q[0];
  assign req1_ready  = ready_q[1];
  assign req0_rvalid = rvalid_q[0];
  assign req1_rvalid = rvalid_q[1];
  assign req0_rdata  = rdata0_q;
  assign req1_rdata  = rdata1_q;
  assign read_write  = read_write_q;
  assign address     = address_q;
  assign bus_clr     = bus_clr_q;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin arbiter and sequencer for the single-port 256x16 sample RAM in the FFT datapath. It accepts word read and write requests from two clients, the sample loader (port 0) and the butterfly engine (port 1), and grants one at a time. It drives the RAM's `read_write`, `address` and `bus_clr` controls, owns the bidirectional data bus during writes, and returns read data to the granted client.

## Interface
- `ADDR_W`, default 8: RAM address width.
- `DATA_W`, default 16: RAM data width.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `reqN_valid`  in  1  request pending (N = 0, 1); held until `reqN_ready` is seen.
- `reqN_write`  in  1  1 = write, 0 = read.
- `reqN_addr`  in  ADDR_W  word address.
- `reqN_wdata`  in  DATA_W  write data.
- `reqN_ready`  out  1  one-cycle accept pulse.
- `reqN_rvalid`  out  1  one-cycle read-data-valid pulse.
- `reqN_rdata`  out  DATA_W  read data; holds until the next read completes for port N.
- `read_write`  out  1  RAM direction; 1 = write, 0 = read.
- `address`  out  ADDR_W  RAM address.
- `bus_clr`  out  1  1 = RAM releases `data_bus` and ignores controls.
- `data_bus`  inout  DATA_W  shared RAM data bus; the arbiter drives it only during write ACCESS.

## Operation
- The FSM has four states: IDLE, ACCESS, READ and TURN. All outputs are registered except the `data_bus` tristate enable, which is decoded from the state.
- IDLE: on an edge where any `reqN_valid` is high, the arbiter:
  - latches that port's write, address and write data;
  - records it as the grant port;
  - moves to ACCESS;
  - sets `reqN_ready` high for exactly the following cycle.
- Round robin: a `last_grant` register tracks the previous winner. When both ports request, the port not equal to `last_grant` wins. A lone requester always wins. `last_grant` updates on every grant.
- ACCESS (1 cycle):
  - `bus_clr` = 0, `address` = latched address, `read_write` = latched write bit.
  - For a write, the arbiter drives `data_bus` with the latched data and the RAM commits the word at the closing edge. Next state is TURN.
  - For a read, `data_bus` stays high-Z. Next state is READ.
- READ (1 cycle):
  - Controls are held and the RAM drives `data_bus`.
  - At the closing edge, `data_bus` is captured into the granted port's `reqN_rdata`, `reqN_rvalid` is pulsed for the next cycle, and the state moves to TURN.
- TURN (1 cycle): `bus_clr` = 1, `read_write` = 0 and `data_bus` is high-Z, giving bus turnaround. Next state is IDLE.
- Requests arriving in non-IDLE states wait. There is no queueing beyond the held `valid`.
- Each client must drop `valid` (or present a new request) on the edge where it samples `ready` = 1. Because the arbiter is in ACCESS at that edge, the same request is never granted twice.

## Timing
- Reset values:
  - `bus_clr` = 1, `read_write` = 0, `address` = 0;
  - all `ready`/`rvalid` = 0 and all `rdata` = 0;
  - `data_bus` high-Z;
  - state IDLE, `last_grant` = 1, so port 0 wins the first contention.
- Edge E0 is the grant edge (IDLE with `valid`):
  - `ready` and ACCESS are active during E0–E1;
  - a write is committed in RAM at E1;
  - read data is captured at E2 and `rvalid` is high during E2–E3;
  - the state is back in IDLE after E2 for a write and after E3 for a read.
- Throughput: one write per 3 cycles, one read per 4 cycles.
- Bus ownership:
  - The arbiter and the RAM never drive `data_bus` in the same cycle.
  - At least one TURN cycle with `bus_clr` = 1 separates any RAM-driven cycle from the next arbiter-driven cycle.
- Reset asserted mid-operation (any state): the arbiter returns to reset values immediately, asynchronously. The in-flight request is dropped with no `rvalid`, and the write is not guaranteed to be committed if reset occurs before E1. Clients re-issue after reset.
- The port-1 grant edge is sampled the same as port 0; there is no priority bias other than `last_grant`.

## Test plan
- Write then read:
  - stimulus: port 0 writes 0xBEEF to 0x12, then reads 0x12;
  - required: `ready` pulses once per request; `rvalid0` is high 2 cycles after the read grant with `rdata0` = 0xBEEF; `rvalid1` stays 0.
- Contention after reset:
  - stimulus: both ports request simultaneously, port 0 writing 0x1111 to 0x00 and port 1 writing 0x2222 to 0x01;
  - required: port 0 is granted first and port 1 is granted at the next IDLE, exactly 3 cycles later; a read-back of both addresses returns 0x1111 and 0x2222.
- Fairness:
  - stimulus: both ports hold continuous read requests for 8 grants;
  - required: grants alternate 0, 1, 0, 1, … and no port is granted twice in a row.
- Reset during READ:
  - stimulus: assert `reset` one cycle after a port-1 read grant;
  - required: `rvalid1` never pulses, `rdata1` = 0, `bus_clr` = 1 immediately, and the next request after deassertion is served normally.
- Bus discipline:
  - stimulus: a random mix of 200 reads and writes;
  - required: `data_bus` is driven by the arbiter only in write ACCESS cycles, never X or contended; every read returns the last value written to that address.
